// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Owns the instruction RAM address/write port. Loads a program
//                from a byte-serial source (little-endian, four bytes per
//                word) while holding the core in reset, then hands the RAM
//                read address to the fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  loadStart_i,
  input  logic [ADDR_WIDTH:0]   wordCount_i,
  input  logic                  byteValid_i,
  input  logic [7:0]            byteData_i,
  output logic                  byteReady_o,
  input  logic [ADDR_WIDTH-1:0] cpuAddr_i,
  output logic                  cpuStall_o,
  output logic                  cpuResetHold_o,
  output logic [ADDR_WIDTH-1:0] ramAddr_o,
  output logic [DATA_WIDTH-1:0] ramWriteData_o,
  output logic                  ramWriteEnable_o,
  output logic                  loadDone_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_RUN   = 2'd3;

  // Largest legal load: the whole RAM.
  localparam logic [ADDR_WIDTH:0] c_MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]            state_q, state_d;
  // One bit wider than the RAM address so a full-RAM load can count to 1024.
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   target_q, target_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH:0]   w_clamped;
  logic [ADDR_WIDTH:0]   w_ptr_next;

  assign w_clamped  = (wordCount_i > c_MAX_WORDS) ? c_MAX_WORDS : wordCount_i;
  assign w_ptr_next = ptr_q + 1'b1;

  // Next-state logic: load sequencing, byte assembly and word pointer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    case (state_q)
      c_IDLE, c_RUN: begin
        if (loadStart_i) begin
          target_d = w_clamped;
          ptr_d    = '0;
          cnt_d    = '0;
          shift_d  = '0;
          if (w_clamped == '0) begin
            state_d = c_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = c_LOAD;
          end
        end
      end
      c_LOAD: begin
        if (byteValid_i) begin
          // Shifting in from the top leaves the first byte in [7:0].
          shift_d = {byteData_i, shift_q[DATA_WIDTH-1:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = c_WRITE;
          end
        end
      end
      c_WRITE: begin
        ptr_d = w_ptr_next;
        cnt_d = '0;
        if (w_ptr_next == target_q) begin
          state_d = c_RUN;
          done_d  = 1'b1;
        end else begin
          state_d = c_LOAD;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // State registers with asynchronous reset; a reset drops any partial word.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= c_IDLE;
      ptr_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

  // Output decode; in RUN the fetch address passes straight through so the
  // RAM read stays same-cycle.
  always_comb begin
    byteReady_o      = (state_q == c_LOAD);
    ramWriteEnable_o = (state_q == c_WRITE);
    ramWriteData_o   = (state_q == c_WRITE) ? shift_q : '0;
    cpuStall_o       = (state_q != c_RUN);
    cpuResetHold_o   = (state_q != c_RUN);
    loadDone_o       = done_q;
    case (state_q)
      c_LOAD, c_WRITE: ramAddr_o = ptr_q[ADDR_WIDTH-1:0];
      c_RUN:           ramAddr_o = cpuAddr_i;
      default:         ramAddr_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_loader
//  Description : Directed bench for imem_boot_loader with a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loadStart;
  logic [10:0] wordCount;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteReady;
  logic [9:0]  cpuAddr;
  logic        cpuStall;
  logic        cpuResetHold;
  logic [9:0]  ramAddr;
  logic [31:0] ramWriteData;
  logic        ramWriteEnable;
  logic        loadDone;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected RAM writes: {address, data}.
  logic [41:0] exp_q[$];
  int writes   = 0;
  int accepted = 0;
  int dones    = 0;
  logic prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clock_i          (clk),
    .reset_ni         (rst_n),
    .loadStart_i      (loadStart),
    .wordCount_i      (wordCount),
    .byteValid_i      (byteValid),
    .byteData_i       (byteData),
    .byteReady_o      (byteReady),
    .cpuAddr_i        (cpuAddr),
    .cpuStall_o       (cpuStall),
    .cpuResetHold_o   (cpuResetHold),
    .ramAddr_o        (ramAddr),
    .ramWriteData_o   (ramWriteData),
    .ramWriteEnable_o (ramWriteEnable),
    .loadDone_o       (loadDone)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write/handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byteValid && byteReady) accepted++;
      if (loadDone) dones++;
      if (ramWriteEnable) begin
        writes++;
        check("we_not_back_to_back", {63'd0, prev_we}, 64'd0);
        check("ready_low_in_write", {63'd0, byteReady}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          logic [41:0] e;
          e = exp_q.pop_front();
          check("write_addr", {54'd0, ramAddr}, {54'd0, e[41:32]});
          check("write_data", {32'd0, ramWriteData}, {32'd0, e[31:0]});
        end
      end
      prev_we = ramWriteEnable;
    end else begin
      prev_we = 1'b0;
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [10:0] n);
    loadStart = 1'b1;
    wordCount = n;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    int gap;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) tick();
    byteValid = 1'b1;
    byteData  = b;
    n = 0;
    @(negedge clk);
    while (!byteReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byteReady) check("byte_timeout", 64'd1, 64'd0);
    tick();
    byteValid = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [31:0] w, input int max_gap);
    exp_q.push_back({addr, w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  // Waits for loadDone, then checks it lasted one cycle and the core is released.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!loadDone && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'd0, loadDone}, 64'd1);
    @(negedge clk);
    check("done_one_cycle", {63'd0, loadDone}, 64'd0);
    check("run_hold", {63'd0, cpuResetHold}, 64'd0);
    check("run_stall", {63'd0, cpuStall}, 64'd0);
    tick();
  endtask

  initial begin
    int w0;
    int d0;
    rst_n     = 1'b0;
    loadStart = 1'b0;
    wordCount = '0;
    byteValid = 1'b0;
    byteData  = '0;
    cpuAddr   = '0;
    #12;
    // Reset state.
    check("rst_ready", {63'd0, byteReady}, 64'd0);
    check("rst_we", {63'd0, ramWriteEnable}, 64'd0);
    check("rst_wdata", {32'd0, ramWriteData}, 64'd0);
    check("rst_addr", {54'd0, ramAddr}, 64'd0);
    check("rst_stall", {63'd0, cpuStall}, 64'd1);
    check("rst_hold", {63'd0, cpuResetHold}, 64'd1);
    check("rst_done", {63'd0, loadDone}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic two-word load.
    start_load(11'd2);
    send_word(10'd0, 32'h00500013, 0);
    send_word(10'd1, 32'hDEADBEEF, 0);
    wait_done(20);
    check("basic_writes", writes, 2);
    check("basic_dones", dones, 1);

    // RUN: address pass-through.
    for (int i = 0; i < 4; i++) begin
      cpuAddr = 10'(i);
      #1;
      check("run_addr", {54'd0, ramAddr}, i);
      check("run_we", {63'd0, ramWriteEnable}, 64'd0);
      tick();
    end

    // Backpressure, three words.
    w0 = writes;
    d0 = accepted;
    start_load(11'd3);
    send_word(10'd0, 32'h11223344, 3);
    send_word(10'd1, 32'hA5A55A5A, 3);
    send_word(10'd2, 32'h0BADF00D, 3);
    wait_done(20);
    check("bp_writes", writes - w0, 3);
    check("bp_bytes", accepted - d0, 12);

    // Zero-length load from RUN.
    w0 = writes;
    start_load(11'd0);
    @(negedge clk);
    check("zero_done", {63'd0, loadDone}, 64'd1);
    @(negedge clk);
    check("zero_done_drop", {63'd0, loadDone}, 64'd0);
    check("zero_writes", writes - w0, 0);
    tick();

    // Oversize request clamps to the full RAM.
    w0 = writes;
    start_load(11'd1500);
    for (int i = 0; i < 1024; i++) send_word(10'(i), 32'hC3000000 ^ 32'(i * 32'h00010203), 0);
    wait_done(20);
    check("full_writes", writes - w0, 1024);

    // Reset after two bytes of the second word.
    start_load(11'd3);
    send_word(10'd0, 32'h01020304, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, byteReady}, 64'd0);
    check("mid_rst_we", {63'd0, ramWriteEnable}, 64'd0);
    check("mid_rst_addr", {54'd0, ramAddr}, 64'd0);
    check("mid_rst_stall", {63'd0, cpuStall}, 64'd1);
    check("mid_rst_hold", {63'd0, cpuResetHold}, 64'd1);
    check("mid_rst_done", {63'd0, loadDone}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    w0 = writes;
    start_load(11'd1);
    send_word(10'd0, 32'hCAFEBABE, 0);
    wait_done(20);
    check("post_rst_writes", writes - w0, 1);

    // loadStart mid-load is ignored.
    w0 = writes;
    start_load(11'd2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    start_load(11'd5);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    exp_q.push_front({10'd0, 32'h04030201});
    send_word(10'd1, 32'h55667788, 0);
    wait_done(20);
    check("ignore_start_writes", writes - w0, 2);

    // loadStart in RUN reloads from address 0.
    start_load(11'd1);
    #1;
    check("reload_hold", {63'd0, cpuResetHold}, 64'd1);
    check("reload_stall", {63'd0, cpuStall}, 64'd1);
    check("reload_addr", {54'd0, ramAddr}, 64'd0);
    tick();
    send_word(10'd0, 32'h12345678, 0);
    wait_done(20);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
